// File: rtl/st7789_pkg.sv
// ST7789 write-stream decoder: command codes, FSM states, RGB565 layout.
package st7789_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CASET,
    S_RASET,
    S_RAMWR,
    S_IGNORE
  } state_t;

  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_LSB = 0;

  function automatic logic [15:0] rgb565(
    input logic [4:0] r,
    input logic [5:0] g,
    input logic [4:0] b
  );
    return (16'(r) << RGB_R_LSB)
         | (16'(g) << RGB_G_LSB)
         | (16'(b) << RGB_B_LSB);
  endfunction

endpackage

// File: rtl/st7789_spi_rx_byte.sv
// Oversampling SPI byte receiver: synchronizers, edge detect, shifter,
// idle realignment and optional chip-select framing.
module spi_byte_rx #(
  parameter int c_clk_polarity = 1,
  parameter int c_clk_phase    = 0,
  parameter int c_use_csn      = 0,
  parameter int c_idle_cycles  = 64
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  input  logic       spi_csn,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
);

  localparam logic IDLE_LVL = (c_clk_polarity != 0);
  localparam bit   SMP_RISE = (c_clk_polarity == c_clk_phase);
  localparam int   IW       = $clog2(c_idle_cycles + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(c_idle_cycles);

  logic [2:0]    sclk;
  logic [1:0]    mosi_s;
  logic [1:0]    dc_s;
  logic [1:0]    csn_s;
  logic [6:0]    shift;
  logic [2:0]    bit_cnt;
  logic [IW-1:0] idle_cnt;
  logic          done;
  logic          sample;
  logic          last;
  logic          csn_clr;
  logic          idle_clr;

  assign sample = SMP_RISE ? (sclk[1] & ~sclk[2])
                           : (~sclk[1] & sclk[2]);
  assign last     = sample && (bit_cnt == 3'd7);
  assign csn_clr  = (c_use_csn != 0) && csn_s[1];
  assign idle_clr = (idle_cnt == IDLE_MAX);

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sclk   <= {3{IDLE_LVL}};
      mosi_s <= '0;
      dc_s   <= '0;
      csn_s  <= 2'b11;
    end else begin
      sclk   <= {sclk[1:0], spi_clk};
      mosi_s <= {mosi_s[0], spi_mosi};
      dc_s   <= {dc_s[0], spi_dc};
      csn_s  <= {csn_s[0], spi_csn};
    end
  end

  // The 8th edge wins over a coincident csn clear; idle clear never
  // swallows the first bit of a new byte.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      shift      <= '0;
      bit_cnt    <= '0;
      idle_cnt   <= '0;
      done       <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
    end else begin
      done       <= last;
      byte_valid <= done;
      if (sample)
        idle_cnt <= '0;
      else if (!idle_clr)
        idle_cnt <= idle_cnt + 1'b1;
      if (last) begin
        byte_data <= {shift, mosi_s[1]};
        byte_dc   <= dc_s[1];
        bit_cnt   <= '0;
      end else if (csn_clr) begin
        bit_cnt <= '0;
      end else if (sample) begin
        shift   <= {shift[5:0], mosi_s[1]};
        bit_cnt <= bit_cnt + 3'd1;
      end else if (idle_clr) begin
        bit_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/st7789_spi_rx.sv
// ST7789 write-stream decoder: command FSM, address window and
// pixel counters producing an (x, y, RGB565) pixel stream.
module st7789_spi_rx
  import st7789_pkg::*;
#(
  parameter int c_clk_polarity = 1,
  parameter int c_clk_phase    = 0,
  parameter int c_use_csn      = 0,
  parameter int c_x_size       = 240,
  parameter int c_y_size       = 240,
  parameter int c_coord_bits   = 9,
  parameter int c_idle_cycles  = 64
) (
  input  logic                    clk,
  input  logic                    resetq,
  input  logic                    spi_clk,
  input  logic                    spi_mosi,
  input  logic                    spi_dc,
  input  logic                    spi_csn,
  output logic                    cmd_valid,
  output logic [7:0]              cmd_byte,
  output logic                    pix_valid,
  output logic [c_coord_bits-1:0] pix_x,
  output logic [c_coord_bits-1:0] pix_y,
  output logic [15:0]             pix_color,
  output logic                    frame_start
);

  localparam int CB = c_coord_bits;
  localparam logic [CB-1:0] XE_RST = CB'(c_x_size - 1);
  localparam logic [CB-1:0] YE_RST = CB'(c_y_size - 1);

  logic          byte_valid;
  logic          byte_dc;
  logic [7:0]    byte_data;
  state_t        state;
  state_t        state_n;
  logic [1:0]    arg_idx;
  logic [7:0]    hi;
  logic          hi_pend;
  logic [CB-1:0] xs, xe, ys, ye;
  logic [CB-1:0] x, y;
  logic [CB-1:0] coord;
  logic          is_cmd;
  logic          is_data;

  spi_byte_rx #(
    .c_clk_polarity (c_clk_polarity),
    .c_clk_phase    (c_clk_phase),
    .c_use_csn      (c_use_csn),
    .c_idle_cycles  (c_idle_cycles)
  ) u_rx (
    .clk        (clk),
    .resetq     (resetq),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_dc     (spi_dc),
    .spi_csn    (spi_csn),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dc    (byte_dc)
  );

  assign is_cmd  = byte_valid && !byte_dc;
  assign is_data = byte_valid && byte_dc;
  assign coord   = CB'({hi, byte_data});

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (is_cmd) begin
      unique case (1'b1)
        byte_data == CMD_CASET:   state_n = S_CASET;
        byte_data == CMD_RASET:   state_n = S_RASET;
        byte_data == CMD_RAMWR:   state_n = S_RAMWR;
        byte_data == CMD_SWRESET: state_n = S_IDLE;
        default:                  state_n = S_IGNORE;
      endcase
    end else if (is_data && arg_idx == 2'd3 &&
                 (state == S_CASET || state == S_RASET)) begin
      state_n = S_IGNORE;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      cmd_valid   <= 1'b0;
      cmd_byte    <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_color   <= '0;
      frame_start <= 1'b0;
      arg_idx     <= '0;
      hi          <= '0;
      hi_pend     <= 1'b0;
      xs          <= '0;
      xe          <= XE_RST;
      ys          <= '0;
      ye          <= YE_RST;
      x           <= '0;
      y           <= '0;
    end else begin
      cmd_valid   <= 1'b0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      if (is_cmd) begin
        cmd_valid <= 1'b1;
        cmd_byte  <= byte_data;
        arg_idx   <= '0;
        hi_pend   <= 1'b0;
        if (byte_data == CMD_RAMWR) begin
          frame_start <= 1'b1;
          x           <= xs;
          y           <= ys;
        end
        if (byte_data == CMD_SWRESET) begin
          xs <= '0;
          xe <= XE_RST;
          ys <= '0;
          ye <= YE_RST;
        end
      end else if (is_data) begin
        unique case (state)
          S_CASET, S_RASET: begin
            arg_idx <= arg_idx + 2'd1;
            if (!arg_idx[0]) begin
              hi <= byte_data;
            end else if (state == S_CASET) begin
              if (arg_idx[1]) xe <= coord;
              else            xs <= coord;
            end else begin
              if (arg_idx[1]) ye <= coord;
              else            ys <= coord;
            end
          end
          S_RAMWR: begin
            if (!hi_pend) begin
              hi      <= byte_data;
              hi_pend <= 1'b1;
            end else begin
              hi_pend   <= 1'b0;
              pix_valid <= 1'b1;
              pix_x     <= x;
              pix_y     <= y;
              pix_color <= {hi, byte_data};
              if (x == xe) begin
                x <= xs;
                y <= (y == ye) ? ys : y + 1'b1;
              end else begin
                x <= x + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_st7789_spi_rx.sv
// Bench for st7789_spi_rx: directed vector table, corner sequences and
// randomized command streams checked against a behavioural panel model.
module tb_st7789_spi_rx;
  import st7789_pkg::*;

  localparam int IDLE = 64;
  localparam int HALF = 4;
  localparam int M    = 512;

  logic clk = 1'b0;
  logic resetq = 1'b0;
  logic spi_clk = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_dc = 1'b0;
  logic spi_csn = 1'b0;

  logic       cmd_valid, pix_valid, frame_start;
  logic [7:0] cmd_byte;
  logic [8:0] pix_x, pix_y;
  logic [15:0] pix_color;

  logic       cmd_valid_c, pix_valid_c, frame_start_c;
  logic [7:0] cmd_byte_c;
  logic [8:0] pix_x_c, pix_y_c;
  logic [15:0] pix_color_c;

  always #5 clk = ~clk;

  st7789_spi_rx dut (
    .clk(clk), .resetq(resetq), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_dc(spi_dc), .spi_csn(spi_csn),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_color(pix_color), .frame_start(frame_start)
  );

  st7789_spi_rx #(.c_use_csn(1)) dut_c (
    .clk(clk), .resetq(resetq), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_dc(spi_dc), .spi_csn(spi_csn),
    .cmd_valid(cmd_valid_c), .cmd_byte(cmd_byte_c),
    .pix_valid(pix_valid_c), .pix_x(pix_x_c), .pix_y(pix_y_c),
    .pix_color(pix_color_c), .frame_start(frame_start_c)
  );

  typedef struct {int x; int y; int c;} pix_t;
  typedef struct {
    bit dc; logic [7:0] b; bit pv; int x; int y; int c;
  } vec_t;

  pix_t got_pix[$], mdl_pix[$];
  int   got_cmd[$], got_cmd_c[$], mdl_cmd[$];
  int   got_frames = 0, mdl_frames = 0;
  int   n_chk = 0, n_pass = 0;
  vec_t vecs[$];

  always @(negedge clk) begin
    if (pix_valid)
      got_pix.push_back('{int'(pix_x), int'(pix_y), int'(pix_color)});
    if (cmd_valid) got_cmd.push_back(int'(cmd_byte));
    if (frame_start) got_frames++;
    if (cmd_valid_c) got_cmd_c.push_back(int'(cmd_byte_c));
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
  endtask

  // Panel model: window, write pointer and argument bytes as integers.
  int m_xs, m_xe, m_ys, m_ye, m_x, m_y, m_mode, m_hi;
  int m_args[$];

  task automatic model_reset();
    m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 239;
    m_x = 0; m_y = 0; m_mode = 0; m_hi = -1;
    m_args.delete();
  endtask

  task automatic model_byte(input bit dc, input int b);
    int n, v;
    if (!dc) begin
      mdl_cmd.push_back(b);
      m_args.delete();
      m_hi = -1;
      case (b)
        'h2A: m_mode = 1;
        'h2B: m_mode = 2;
        'h2C: begin m_mode = 3; m_x = m_xs; m_y = m_ys; mdl_frames++; end
        'h01: begin model_reset(); end
        default: m_mode = 4;
      endcase
    end else if (m_mode == 1 || m_mode == 2) begin
      m_args.push_back(b);
      n = m_args.size();
      if (n == 2 || n == 4) begin
        v = (m_args[n-2] * 256 + m_args[n-1]) % M;
        if (m_mode == 1 && n == 2) m_xs = v;
        if (m_mode == 1 && n == 4) m_xe = v;
        if (m_mode == 2 && n == 2) m_ys = v;
        if (m_mode == 2 && n == 4) m_ye = v;
        if (n == 4) m_mode = 4;
      end
    end else if (m_mode == 3) begin
      if (m_hi < 0) m_hi = b;
      else begin
        mdl_pix.push_back('{m_x, m_y, m_hi * 256 + b});
        m_hi = -1;
        if (m_x == m_xe) begin
          m_x = m_xs;
          m_y = (m_y == m_ye) ? m_ys : (m_y + 1) % M;
        end else m_x = (m_x + 1) % M;
      end
    end
  endtask

  task automatic spi_bit(input bit v);
    @(negedge clk);
    spi_mosi = v;
    repeat (HALF) @(negedge clk);
    spi_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_clk = 1'b1;
  endtask

  task automatic send_byte(input bit dc, input logic [7:0] b);
    spi_dc = dc;
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    model_byte(dc, int'(b));
  endtask

  task automatic clear_all();
    got_pix.delete(); mdl_pix.delete();
    got_cmd.delete(); mdl_cmd.delete(); got_cmd_c.delete();
    got_frames = 0; mdl_frames = 0;
  endtask

  task automatic compare_model(input string tag);
    check({tag, " pix count"}, got_pix.size(), mdl_pix.size());
    for (int i = 0; i < got_pix.size() && i < mdl_pix.size(); i++) begin
      check($sformatf("%s pix%0d x", tag, i), got_pix[i].x, mdl_pix[i].x);
      check($sformatf("%s pix%0d y", tag, i), got_pix[i].y, mdl_pix[i].y);
      check($sformatf("%s pix%0d c", tag, i), got_pix[i].c, mdl_pix[i].c);
    end
    check({tag, " cmd count"}, got_cmd.size(), mdl_cmd.size());
    for (int i = 0; i < got_cmd.size() && i < mdl_cmd.size(); i++)
      check($sformatf("%s cmd%0d", tag, i), got_cmd[i], mdl_cmd[i]);
    check({tag, " frames"}, got_frames, mdl_frames);
    clear_all();
  endtask

  task automatic check_zero(input string tag);
    check({tag, " cmd_valid"}, cmd_valid, 0);
    check({tag, " cmd_byte"}, cmd_byte, 0);
    check({tag, " pix_valid"}, pix_valid, 0);
    check({tag, " pix_x"}, pix_x, 0);
    check({tag, " pix_y"}, pix_y, 0);
    check({tag, " pix_color"}, pix_color, 0);
    check({tag, " frame_start"}, frame_start, 0);
  endtask

  function automatic void add(input bit dc, input logic [7:0] b,
                              input bit pv = 1'b0, input int x = 0,
                              input int y = 0, input int c = 0);
    vecs.push_back('{dc, b, pv, x, y, c});
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int cx[5] = '{10, 11, 10, 11, 10};
    int cy[5] = '{5, 5, 6, 6, 5};
    int op, n;
    logic [15:0] red, green;
    logic [7:0] tmp;

    red   = rgb565(5'h1f, 6'h00, 5'h00);
    green = rgb565(5'h00, 6'h3f, 5'h00);

    // Default window, first RAMWR
    add(0, 8'h2C);
    add(1, red[15:8]);
    add(1, red[7:0], 1, 0, 0, int'(red));
    add(1, green[15:8]);
    add(1, green[7:0], 1, 1, 0, int'(green));
    // 2x2 window that wraps back to its origin
    add(0, 8'h2A);
    add(1, 8'h00); add(1, 8'h0A); add(1, 8'h00); add(1, 8'h0B);
    add(0, 8'h2B);
    add(1, 8'h00); add(1, 8'h05); add(1, 8'h00); add(1, 8'h06);
    add(0, 8'h2C);
    for (int i = 0; i < 5; i++) begin
      tmp = 8'(i);
      add(1, 8'hA0);
      add(1, tmp, 1, cx[i], cy[i], 'hA000 + i);
    end
    // Half pixel discarded by an intervening command
    add(0, 8'h01);
    add(0, 8'h2C);
    add(1, 8'hAA);
    add(0, 8'h00);
    add(0, 8'h2C);
    add(1, 8'h12);
    add(1, 8'h34, 1, 0, 0, 'h1234);

    repeat (2) @(negedge clk);
    check_zero("reset");
    resetq = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    clear_all();

    foreach (vecs[i]) begin
      got_pix.delete();
      send_byte(vecs[i].dc, vecs[i].b);
      repeat (4) @(negedge clk);
      check($sformatf("vec%0d pix count", i), got_pix.size(), vecs[i].pv);
      if (vecs[i].pv && got_pix.size() > 0) begin
        check($sformatf("vec%0d x", i), got_pix[0].x, vecs[i].x);
        check($sformatf("vec%0d y", i), got_pix[0].y, vecs[i].y);
        check($sformatf("vec%0d color", i), got_pix[0].c, vecs[i].c);
      end
      if (!vecs[i].dc)
        check($sformatf("vec%0d cmd_byte", i), cmd_byte, vecs[i].b);
    end
    check("table frame_start count", got_frames, 4);
    clear_all();

    // Idle realign after a partial byte
    spi_dc = 1'b0;
    spi_bit(1); spi_bit(0); spi_bit(1);
    repeat (IDLE + 2) @(negedge clk);
    send_byte(0, 8'h2C);
    repeat (8) @(negedge clk);
    check("idle cmd count", got_cmd.size(), 1);
    if (got_cmd.size() > 0) check("idle cmd value", got_cmd[0], 'h2C);
    check("idle cmd_byte", cmd_byte, 'h2C);
    clear_all();

    // csn framing on the 8-pin variant
    spi_dc = 1'b0;
    spi_bit(1); spi_bit(0); spi_bit(1); spi_bit(1); spi_bit(0);
    @(negedge clk) spi_csn = 1'b1;
    repeat (10) @(negedge clk);
    spi_csn = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(0, 8'h2A);
    repeat (IDLE + 10) @(negedge clk);
    check("csn cmd count", got_cmd_c.size(), 1);
    if (got_cmd_c.size() > 0) check("csn cmd value", got_cmd_c[0], 'h2A);
    check("csn cmd_byte", cmd_byte_c, 'h2A);
    clear_all();

    // csn toggling is ignored by the 7-pin variant
    spi_dc = 1'b0;
    spi_bit(0); spi_bit(0); spi_bit(1); spi_bit(0);
    @(negedge clk) spi_csn = 1'b1;
    repeat (3) @(negedge clk);
    spi_csn = 1'b0;
    spi_bit(1); spi_bit(0); spi_bit(1); spi_bit(1);
    model_byte(0, 'h2B);
    repeat (IDLE + 10) @(negedge clk);
    check("nocsn cmd count", got_cmd.size(), 1);
    if (got_cmd.size() > 0) check("nocsn cmd value", got_cmd[0], 'h2B);
    clear_all();

    // SWRESET restores the default window
    send_byte(0, 8'h2A);
    send_byte(1, 8'h00); send_byte(1, 8'h10);
    send_byte(1, 8'h00); send_byte(1, 8'h20);
    send_byte(0, 8'h01);
    send_byte(0, 8'h2C);
    send_byte(1, 8'hAB); send_byte(1, 8'hCD);
    repeat (8) @(negedge clk);
    check("swreset pix count", got_pix.size(), 1);
    if (got_pix.size() > 0) begin
      check("swreset x", got_pix[0].x, 0);
      check("swreset y", got_pix[0].y, 0);
      check("swreset color", got_pix[0].c, 'hABCD);
    end
    clear_all();

    // Reset in the middle of a pixel
    send_byte(0, 8'h2C);
    send_byte(1, 8'h55);
    spi_dc = 1'b1;
    spi_bit(1); spi_bit(0); spi_bit(1); spi_bit(0);
    @(negedge clk) resetq = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("midreset");
    resetq = 1'b1;
    repeat (IDLE + 10) @(negedge clk);
    check("midreset pix count", got_pix.size(), 0);
    check_zero("after reset");
    model_reset();
    clear_all();

    for (int it = 0; it < 25; it++) begin
      op = $urandom_range(0, 5);
      case (op)
        0, 1: begin
          send_byte(0, op == 0 ? 8'h2A : 8'h2B);
          repeat (2) begin
            send_byte(1, 8'($urandom_range(0, 1)));
            send_byte(1, 8'($urandom_range(0, 255)));
          end
        end
        2: begin
          send_byte(0, 8'h2C);
          n = $urandom_range(0, 11);
          repeat (n) send_byte(1, 8'($urandom));
        end
        3: send_byte(0, 8'h01);
        4: begin
          send_byte(0, 8'($urandom));
          n = $urandom_range(0, 2);
          repeat (n) send_byte(1, 8'($urandom));
        end
        default: begin
          n = $urandom_range(1, 3);
          repeat (n) send_byte(1, 8'($urandom));
        end
      endcase
      repeat (8) @(negedge clk);
      compare_model($sformatf("rnd%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
